sum_block_accumulator: RTL



---
 rtl/sum_block_accumulator_if.sv | 28 ++
 rtl/sum_block_accumulator.sv | 85 ++++++++
 2 files changed

// File: rtl/sum_block_accumulator_if.sv
// Stream bundle between the adder pipeline, the block accumulator and its consumer.
// Handshake: a beat transfers on a clk edge where valid && ready; the producer holds data until then.
interface sum_block_accumulator_if #(
  parameter int IN_W   = 12,
  parameter int LOG2_N = 2
);
  localparam int ACC_W = IN_W + LOG2_N;

  logic [IN_W-1:0]   in_data;
  logic              in_valid;
  logic              in_ready;
  logic              clear;
  logic [ACC_W-1:0]  out_sum;
  logic [IN_W-1:0]   out_avg;
  logic              out_valid;
  logic              out_ready;
  logic [LOG2_N-1:0] sample_cnt;

  modport master (
    output in_data, in_valid, clear, out_ready,
    input  in_ready, out_sum, out_avg, out_valid, sample_cnt
  );

  modport slave (
    input  in_data, in_valid, clear, out_ready,
    output in_ready, out_sum, out_avg, out_valid, sample_cnt
  );
endinterface

// File: rtl/sum_block_accumulator.sv
// Accumulates blocks of 2^LOG2_N unsigned samples and emits block sum and truncated average
// through a one-deep output buffer, so the next block can fill while a result waits.
module sum_block_accumulator #(
  parameter int IN_W   = 12,
  parameter int LOG2_N = 2
) (
  input  logic clk,
  input  logic rst_n,
  sum_block_accumulator_if.slave bus,
  output logic fsm_state
);
  localparam int ACC_W = IN_W + LOG2_N;
  localparam logic [LOG2_N-1:0] ONE      = 1;
  localparam logic [LOG2_N-1:0] LAST_CNT = '1;
  localparam logic [LOG2_N-1:0] PRE_CNT  = LAST_CNT - ONE;

  typedef enum logic {ACCUM = 1'b0, LAST = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q;
  logic [LOG2_N-1:0] cnt_q;
  logic [ACC_W-1:0]  sum_q;
  logic [IN_W-1:0]   avg_q;
  logic              valid_q;

  logic              ready;
  logic              accept;
  logic              complete;
  logic [ACC_W-1:0]  sum_next;

  // Only the block-completing sample has to wait for a stalled consumer.
  assign ready    = rst_n && !bus.clear && !(valid_q && !bus.out_ready && state_q == LAST);
  assign accept   = bus.in_valid && ready;
  assign complete = accept && state_q == LAST;
  assign sum_next = acc_q + ACC_W'(bus.in_data);

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = ACCUM;
    end else if (accept) begin
      if (state_q == LAST)
        state_d = ACCUM;
      else if (cnt_q == PRE_CNT)
        state_d = LAST;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      avg_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.clear) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (complete) begin
        acc_q <= '0;
        cnt_q <= '0;
        sum_q <= sum_next;
        avg_q <= sum_next[ACC_W-1:LOG2_N];
      end else if (accept) begin
        acc_q <= sum_next;
        cnt_q <= cnt_q + ONE;
      end
      // A completion on the consume edge reloads the buffer without a bubble.
      if (complete)
        valid_q <= 1'b1;
      else if (bus.out_ready)
        valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_sum    = sum_q;
  assign bus.out_avg    = avg_q;
  assign bus.out_valid  = valid_q;
  assign bus.sample_cnt = cnt_q;
  assign fsm_state      = (state_q == LAST);
endmodule
